// File: rtl/replace_pkg.sv
// Shared types and constants for the replacement-policy engine.
// Contents: policy mode encoding, controller state encoding, RR LFSR tap mask.
package replace_pkg;

    typedef enum logic [1:0] {
        LRU  = 2'd0,
        RR   = 2'd1,
        LFU  = 2'd2,
        FIFO = 2'd3
    } replace_mode_e;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } replace_state_e;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: state bits 0,2,3,5 feed bit 15.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/replace_policy_unit_lfsr16.sv
// 16-bit Fibonacci LFSR used as the random source for RR victim selection.
// Ports: clk, rst_n (async active-low), en (advance one step), state (current value).
module lfsr16
    import replace_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] state
);

    // Shift right; feedback parity enters at the top bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (en) begin
            state <= {^(state & LFSR_TAPS), state[15:1]};
        end
    end

endmodule

// File: rtl/replace_policy_unit.sv
// Multi-set replacement-policy engine (LRU / RR / LFU / FIFO) with per-set state.
// Returns a one-hot hit-or-victim line one cycle after an accepted request.
// Ports: clk_i, rst_ni (async active-low); req_valid_i/req_ready_o handshake;
//        set_i set index; mode_i policy select; flush_i reinit request;
//        valid_line_i / hit_line_i per-way status of the addressed set;
//        resp_valid_o pulse with out_line_o (one-hot) and evict_o.
// Optional: define REPLACE_LFU_AGING_EN to age a set's LFU counters when a hit saturates.
module replace_policy_unit
    import replace_pkg::*;
#(
    parameter int unsigned SET_SIZE  = 4,
    parameter int unsigned SET_NUM   = 16,
    parameter int unsigned CNT_WIDTH = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [$clog2(SET_NUM)-1:0] set_i,
    input  logic [1:0]                 mode_i,
    input  logic                       flush_i,
    input  logic [SET_SIZE-1:0]        valid_line_i,
    input  logic [SET_SIZE-1:0]        hit_line_i,
    output logic                       resp_valid_o,
    output logic [SET_SIZE-1:0]        out_line_o,
    output logic                       evict_o
);

    localparam int unsigned IDX_W = $clog2(SET_SIZE);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    replace_state_e state_q, state_d;
    replace_mode_e  mode_q;
    logic           accept, clear;

    logic [IDX_W-1:0]     lru_rank [SET_NUM][SET_SIZE];
    logic [CNT_WIDTH-1:0] lfu_cnt  [SET_NUM][SET_SIZE];
    logic [IDX_W-1:0]     fifo_ptr [SET_NUM];

    logic                 hit_any, set_full, evict_c;
    logic [IDX_W-1:0]     hit_idx, free_idx, lru_vic, lfu_vic, pol_vic, acc_idx;
    logic [IDX_W-1:0]     lru_next [SET_SIZE];
    logic [CNT_WIDTH-1:0] lfu_next [SET_SIZE];

    logic [15:0] lfsr_state;
    logic        lfsr_unused;

    assign req_ready_o = (state_q == ST_READY);
    assign lfsr_unused = ^lfsr_state[15:IDX_W];

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .en    (accept && evict_c && (mode_q == RR)),
        .state (lfsr_state)
    );

    // Controller state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_READY;
            mode_q  <= LRU;
        end else begin
            state_q <= state_d;
            if (clear) mode_q <= replace_mode_e'(mode_i);
        end
    end

    // A flush or mode change blocks the request in the same cycle and schedules a CLEAR
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        clear   = 1'b0;
        case (state_q)
            ST_READY: begin
                if (flush_i || (replace_mode_e'(mode_i) != mode_q)) state_d = ST_CLEAR;
                else                                                   accept  = req_valid_i;
            end
            ST_CLEAR: begin
                clear   = 1'b1;
                state_d = ST_READY;
            end
            default: state_d = ST_READY;
        endcase
    end

    // Victim / accessed-way selection for the addressed set
    always_comb begin
        hit_any  = |hit_line_i;
        set_full = &valid_line_i;
        evict_c  = !hit_any && set_full;
        hit_idx  = '0;
        free_idx = '0;
        lru_vic  = '0;
        lfu_vic  = '0;
        // Descending scan so the lowest matching index wins
        for (int i = SET_SIZE - 1; i >= 0; i--) begin
            if (hit_line_i[i])   hit_idx  = IDX_W'(i);
            if (!valid_line_i[i]) free_idx = IDX_W'(i);
            if (lru_rank[set_i][i] == IDX_W'(SET_SIZE - 1)) lru_vic = IDX_W'(i);
        end
        // Strict less-than keeps the lowest index on ties
        for (int i = 1; i < SET_SIZE; i++) begin
            if (lfu_cnt[set_i][i] < lfu_cnt[set_i][lfu_vic]) lfu_vic = IDX_W'(i);
        end
        case (mode_q)
            LRU:     pol_vic = lru_vic;
            RR:      pol_vic = lfsr_state[IDX_W-1:0];
            LFU:     pol_vic = lfu_vic;
            default: pol_vic = fifo_ptr[set_i];
        endcase
        if (hit_any)        acc_idx = hit_idx;
        else if (!set_full) acc_idx = free_idx;
        else                acc_idx = pol_vic;
    end

    // Next LRU ranks and LFU counters for the addressed set
    always_comb begin
        for (int i = 0; i < SET_SIZE; i++) begin
            if (IDX_W'(i) == acc_idx)                          lru_next[i] = '0;
            else if (lru_rank[set_i][i] < lru_rank[set_i][acc_idx]) lru_next[i] = lru_rank[set_i][i] + IDX_W'(1);
            else                                                lru_next[i] = lru_rank[set_i][i];
            lfu_next[i] = lfu_cnt[set_i][i];
        end
        if (hit_any) begin
            if (lfu_cnt[set_i][acc_idx] != CNT_MAX) begin
                lfu_next[acc_idx] = lfu_cnt[set_i][acc_idx] + CNT_WIDTH'(1);
            end
`ifdef REPLACE_LFU_AGING_EN
            else begin
                for (int i = 0; i < SET_SIZE; i++) lfu_next[i] = lfu_cnt[set_i][i] >> 1;
                lfu_next[acc_idx] = CNT_WIDTH'((CNT_MAX >> 1) + CNT_WIDTH'(1));
            end
`endif
        end else begin
            lfu_next[acc_idx] = CNT_WIDTH'(1);
        end
    end

    // Per-set policy state; only the active policy updates on an accepted access
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SET_NUM; s++) begin
                for (int w = 0; w < SET_SIZE; w++) begin
                    lru_rank[s][w] <= IDX_W'(w);
                    lfu_cnt[s][w]  <= '0;
                end
                fifo_ptr[s] <= '0;
            end
        end else if (clear) begin
            for (int s = 0; s < SET_NUM; s++) begin
                for (int w = 0; w < SET_SIZE; w++) begin
                    lru_rank[s][w] <= IDX_W'(w);
                    lfu_cnt[s][w]  <= '0;
                end
                fifo_ptr[s] <= '0;
            end
        end else if (accept) begin
            case (mode_q)
                LRU: for (int w = 0; w < SET_SIZE; w++) lru_rank[set_i][w] <= lru_next[w];
                LFU: for (int w = 0; w < SET_SIZE; w++) lfu_cnt[set_i][w]  <= lfu_next[w];
                FIFO: if (evict_c) fifo_ptr[set_i] <= fifo_ptr[set_i] + IDX_W'(1);
                default: ;
            endcase
        end
    end

    // Response registers; line and evict hold between responses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_o <= 1'b0;
            out_line_o   <= '0;
            evict_o      <= 1'b0;
        end else begin
            resp_valid_o <= accept;
            if (accept) begin
                out_line_o <= SET_SIZE'(1) << acc_idx;
                evict_o    <= evict_c;
            end
        end
    end

endmodule
